// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the serial-bus round-robin arbiter.
package bus_arb_pkg;

  localparam int NODES      = 16;
  localparam int ID_W       = 4;
  localparam int HDR_BITS   = 11;
  localparam int CRC_BITS   = 4;
  localparam int IFG_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE,
    TX,
    GAP
  } state_e;

  // Frame length for a 2-bit mode: header + (8 << mod) data bits + CRC.
  function automatic logic [6:0] flen(input logic [1:0] mod);
    return 7'(HDR_BITS + CRC_BITS) + (7'd8 << mod);
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req at or after rr_ptr, wrapping.
module rr_picker
  import bus_arb_pkg::*;
(
  input  logic [NODES-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic             valid,
  output logic [ID_W-1:0]  winner
);

  logic [NODES-1:0] rot;
  logic [ID_W-1:0]  off;
  logic             found;

  // Rotate so rr_ptr sits at bit 0, priority-encode, then add rr_ptr back.
  always_comb begin
    rot   = NODES'({req, req} >> rr_ptr);
    valid = |req;
    off   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NODES; i++) begin
      if (rot[i] && !found) begin
        off   = ID_W'(i);
        found = 1'b1;
      end
    end
    winner = rr_ptr + off;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter and frame sequencer for the 16-node serial bus.
// Optional inter-frame gap enabled by defining BUS_ARB_IFG_EN.
module bus_arbiter
  import bus_arb_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NODES-1:0]     req,
  input  logic [2*NODES-1:0]   mod_flat,
  output logic [NODES-1:0]     grant,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic [6:0]           tx_bit_idx,
  output logic                 frame_done
);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NODES-1:0] grant_q, grant_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic             busy_q, busy_d;
  logic [6:0]       tx_bit_idx_q, tx_bit_idx_d;
  logic             frame_done_q, frame_done_d;
  logic [6:0]       flen_q, flen_d;
`ifdef BUS_ARB_IFG_EN
  logic [2:0]       gap_cnt_q, gap_cnt_d;
`endif

  logic             pick_valid;
  logic [ID_W-1:0]  pick_id;

  rr_picker u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  // Next-state and output computation for the IDLE/TX/GAP sequencer.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    grant_id_d   = grant_id_q;
    busy_d       = busy_q;
    tx_bit_idx_d = tx_bit_idx_q;
    frame_done_d = 1'b0;
    flen_d       = flen_q;
`ifdef BUS_ARB_IFG_EN
    gap_cnt_d    = gap_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d      = TX;
          grant_d      = NODES'(1) << pick_id;
          grant_id_d   = pick_id;
          busy_d       = 1'b1;
          tx_bit_idx_d = '0;
          flen_d       = flen(mod_flat[{pick_id, 1'b0} +: 2]);
        end
      end
      TX: begin
        if (tx_bit_idx_q == flen_q - 7'd1) begin
          grant_d      = '0;
          busy_d       = 1'b0;
          tx_bit_idx_d = '0;
          frame_done_d = 1'b1;
          rr_ptr_d     = grant_id_q + ID_W'(1);
`ifdef BUS_ARB_IFG_EN
          state_d      = GAP;
          gap_cnt_d    = '0;
`else
          state_d      = IDLE;
`endif
        end else begin
          tx_bit_idx_d = tx_bit_idx_q + 7'd1;
        end
      end
      GAP: begin
`ifdef BUS_ARB_IFG_EN
        if (gap_cnt_q == 3'(IFG_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 3'd1;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      grant_id_q   <= '0;
      busy_q       <= 1'b0;
      tx_bit_idx_q <= '0;
      frame_done_q <= 1'b0;
      flen_q       <= '0;
`ifdef BUS_ARB_IFG_EN
      gap_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      grant_id_q   <= grant_id_d;
      busy_q       <= busy_d;
      tx_bit_idx_q <= tx_bit_idx_d;
      frame_done_q <= frame_done_d;
      flen_q       <= flen_d;
`ifdef BUS_ARB_IFG_EN
      gap_cnt_q    <= gap_cnt_d;
`endif
    end
  end

  assign grant      = grant_q;
  assign grant_id   = grant_id_q;
  assign busy       = busy_q;
  assign tx_bit_idx = tx_bit_idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: table-driven frames plus corner sequences.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = '0;
  logic [31:0] mod_flat = '0;
  logic [15:0] grant;
  logic [3:0]  grant_id;
  logic        busy;
  logic [6:0]  tx_bit_idx;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

`ifdef BUS_ARB_IFG_EN
  localparam int GAP_EXP = 4;
`else
  localparam int GAP_EXP = 0;
`endif

  // node i uses mode i%4
  localparam logic [31:0] M = 32'hE4E4E4E4;

  always #5 clk = ~clk;

  bus_arbiter dut (
    .clock      (clk),
    .reset      (rst),
    .req        (req),
    .mod_flat   (mod_flat),
    .grant      (grant),
    .grant_id   (grant_id),
    .busy       (busy),
    .tx_bit_idx (tx_bit_idx),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [15:0] req;
    logic [31:0] mod;
    int          id;
    int          len;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits for the next grant, then follows the frame to its frame_done cycle.
  // At bit change_at the inputs are replaced to show they are ignored mid-frame.
  task automatic run_frame(input string name, input int exp_id, input int exp_len,
                           input int exp_gap, input int change_at,
                           input logic [15:0] new_req, input logic [31:0] new_mod);
    int gap;
    int len;
    int bad;
    logic [15:0] eg;
    eg  = 16'h0001 << exp_id;
    gap = 0;
    @(negedge clk);
    while (!busy && gap < 200) begin
      gap++;
      @(negedge clk);
    end
    check({name, "_gap"}, 32'(gap), 32'(exp_gap));
    check({name, "_grant"}, 32'(grant), 32'(eg));
    check({name, "_id"}, 32'(grant_id), 32'(exp_id));
    len = 0;
    bad = 0;
    while (busy && len < 200) begin
      if (tx_bit_idx != 7'(len) || grant != eg || grant_id != 4'(exp_id) || frame_done)
        bad++;
      if (len == change_at) begin
        req      = new_req;
        mod_flat = new_mod;
      end
      len++;
      @(negedge clk);
    end
    check({name, "_len"}, 32'(len), 32'(exp_len));
    check({name, "_seq"}, 32'(bad), 32'd0);
    check({name, "_done"}, 32'(frame_done), 32'd1);
    check({name, "_grant_clr"}, 32'(grant), 32'd0);
    check({name, "_idx_clr"}, 32'(tx_bit_idx), 32'd0);
  endtask

  initial begin
    int bad;
    int n;

    tbl[0]  = '{16'h0002, M,            1,  31};
    tbl[1]  = '{16'h0008, 32'h00000000, 3,  23};
    tbl[2]  = '{16'h0008, 32'h55555555, 3,  31};
    tbl[3]  = '{16'h0008, 32'hAAAAAAAA, 3,  47};
    tbl[4]  = '{16'h0008, 32'hFFFFFFFF, 3,  79};
    tbl[5]  = '{16'h0011, M,            4,  23};
    tbl[6]  = '{16'h0011, M,            0,  23};
    tbl[7]  = '{16'h8000, M,            15, 79};
    tbl[8]  = '{16'h0001, M,            0,  23};
    tbl[9]  = '{16'h4000, M,            14, 47};
    tbl[10] = '{16'h0001, M,            0,  23};
    tbl[11] = '{16'h8001, M,            15, 79};
    tbl[12] = '{16'h0C00, M,            10, 47};
    tbl[13] = '{16'h0C00, M,            11, 79};
    tbl[14] = '{16'h0C00, M,            10, 47};

    // Reset state
    req = 16'hFFFF;
    @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_idx", 32'(tx_bit_idx), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_id", 32'(grant_id), 32'd0);
    req = '0;
    rst = 1'b0;

    // No requests: stay idle
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy || grant != '0 || frame_done || tx_bit_idx != '0) bad++;
    end
    check("idle_noreq", 32'(bad), 32'd0);

    // Round robin with all nodes requesting
    req      = 16'hFFFF;
    mod_flat = '0;
    for (int k = 0; k < 17; k++)
      run_frame($sformatf("rr%0d", k), k % 16, 23, (k == 0) ? 0 : GAP_EXP, -1, '0, '0);

    // Table of directed frames
    for (int v = 0; v < 15; v++) begin
      req      = tbl[v].req;
      mod_flat = tbl[v].mod;
      run_frame($sformatf("vec%0d", v), tbl[v].id, tbl[v].len, GAP_EXP, -1, '0, '0);
    end

    // Node 5 drops req and mode changes at bit 4: frame still full length
    req      = 16'h0020;
    mod_flat = M;
    run_frame("drop", 5, 31, GAP_EXP, 4, 16'h0000, 32'h00000000);

    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy || grant != '0 || frame_done) bad++;
    end
    check("idle_after_drop", 32'(bad), 32'd0);

    // New request arrives on the frame_done edge
    req      = 16'h0100;
    mod_flat = M;
    run_frame("same_edge_a", 8, 23, 0, 22, 16'h0200, M);
    run_frame("same_edge_b", 9, 31, GAP_EXP, -1, '0, '0);

    // Reset in the middle of a frame
    req = 16'h0020;
    run_frame("pre_rst", 5, 31, GAP_EXP, -1, '0, '0);
    req = 16'h0041;
    n = 0;
    @(negedge clk);
    while (!busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("mid_id", 32'(grant_id), 32'd6);
    while (busy && tx_bit_idx != 7'd10 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("mid_idx10", 32'(tx_bit_idx), 32'd10);
    rst = 1'b1;
    #1;
    check("abort_grant", 32'(grant), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_idx", 32'(tx_bit_idx), 32'd0);
    check("abort_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    check("abort_done_hold", 32'(frame_done), 32'd0);
    rst = 1'b0;
    run_frame("post_rst", 0, 23, 0, -1, '0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
